// File: rtl/output_arbiter.sv
// output_arbiter: per-output-port packet arbiter for the 5-port mesh router.
// Grants one requesting input port at a time, holds the grant for a whole
// packet, paces flits against destination_full and pulses packet_done on the
// last flit.
// Build option: define ARB_FIXED_PRIORITY_EN for fixed priority (highest
// index wins, no pointer register); default build is round-robin.
module output_arbiter #(
    parameter int NUM_PORTS        = 5,
    parameter int FLITS_PER_PACKET = 8,
    parameter int COUNT_WIDTH      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] request_in,
    input  logic                 destination_full,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 grant_valid,
    output logic                 send_flit,
    output logic                 packet_done
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [NUM_PORTS-1:0]   ONE_P      = NUM_PORTS'(1);
    localparam logic [COUNT_WIDTH-1:0] ONE_C      = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(FLITS_PER_PACKET - 1);

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [NUM_PORTS-1:0]   pick;
    logic                   last_flit;

`ifndef ARB_FIXED_PRIORITY_EN
    // Pointer kept one-hot: bit p set means port p has highest priority.
    // Reset value ONE_P is pointer index 0; advancing is a rotate of the grant.
    logic [NUM_PORTS-1:0]   ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]   upper_req;

    // Round-robin pick: lowest set request at/above the pointer, else lowest overall.
    always_comb begin
        upper_req = request_in & ~(ptr_q - ONE_P);
        if (|upper_req) begin
            pick = upper_req & (~upper_req + ONE_P);
        end else begin
            pick = request_in & (~request_in + ONE_P);
        end
    end
`else
    logic [NUM_PORTS-1:0]   smear;

    // Fixed-priority pick: smear requests downward, keep only the top bit.
    always_comb begin
        smear = request_in;
        for (int unsigned i = 1; i < NUM_PORTS; i++) begin
            smear = smear | (request_in >> i);
        end
        pick = smear & ~(smear >> 1);
    end
`endif

    assign grant_valid = (state_q == BUSY);
    assign grant       = grant_q;
    assign send_flit   = grant_valid & ~destination_full;
    assign last_flit   = (count_q == LAST_COUNT);
    assign packet_done = send_flit & last_flit;

    // State register: grant, flit counter and (round-robin) priority pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            count_q <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            ptr_q   <= ONE_P;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            count_q <= count_d;
`ifndef ARB_FIXED_PRIORITY_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Next-state: arbitrate in IDLE, count flits in BUSY, release on last flit.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        count_d = count_q;
`ifndef ARB_FIXED_PRIORITY_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|request_in) begin
                    grant_d = pick;
                    count_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (send_flit) begin
                    if (last_flit) begin
                        state_d = IDLE;
                        grant_d = '0;
                        count_d = '0;
`ifndef ARB_FIXED_PRIORITY_EN
                        ptr_d   = {grant_q[NUM_PORTS-2:0], grant_q[NUM_PORTS-1]};
`endif
                    end else begin
                        count_d = count_q + ONE_C;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed testbench for output_arbiter. Outputs are checked as the packed
// vector {grant, grant_valid, send_flit, packet_done}, sampled 1-2 time units
// after the rising edge. Honours ARB_FIXED_PRIORITY_EN like the design.
module tb_output_arbiter;

    logic       clk;
    logic       reset;
    logic [4:0] request_in;
    logic       destination_full;
    logic [4:0] grant;
    logic       grant_valid;
    logic       send_flit;
    logic       packet_done;

    int errors;
    int checks;

    output_arbiter #(
        .NUM_PORTS        (5),
        .FLITS_PER_PACKET (8),
        .COUNT_WIDTH      (3)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .request_in       (request_in),
        .destination_full (destination_full),
        .grant            (grant),
        .grant_valid      (grant_valid),
        .send_flit        (send_flit),
        .packet_done      (packet_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {grant, grant_valid, send_flit, packet_done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        request_in       = '0;
        destination_full = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        request_in       = 5'b11111;
        destination_full = 1'b0;
        #1;
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs(), 8'h00);
        end
        tick();
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_held_with_requests: got %b expected %b", obs(), 8'h00);
        end
        request_in = '0;
        reset      = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        request_in = 5'b00100;
        #1;
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL single_idle_before_grant: got %b expected %b", obs(), 8'h00);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs() !== {5'b00100, 1'b1, 1'b1, (k == 7)}) begin
                errors++;
                $display("FAIL single_flit%0d: got %b expected %b", k, obs(),
                         {5'b00100, 1'b1, 1'b1, (k == 7)});
            end
            tick();
        end
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL single_bubble: got %b expected %b", obs(), 8'h00);
        end
        tick();
        checks++;
        if (obs() !== {5'b00100, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_regrant_wrap: got %b expected %b", obs(), {5'b00100, 3'b110});
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_g [4];
        exp_g[0] = 5'b00001;
        exp_g[1] = 5'b00010;
        exp_g[2] = 5'b00100;
        exp_g[3] = 5'b01000;
        do_reset();
        request_in = 5'b11111;
        tick();
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (obs() !== {exp_g[p], 1'b1, 1'b1, (k == 7)}) begin
                    errors++;
                    $display("FAIL rr_pkt%0d_flit%0d: got %b expected %b", p, k, obs(),
                             {exp_g[p], 1'b1, 1'b1, (k == 7)});
                end
                tick();
            end
            checks++;
            if (obs() !== 8'h00) begin
                errors++;
                $display("FAIL rr_bubble%0d: got %b expected %b", p, obs(), 8'h00);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        request_in = 5'b00010;
        tick();
        for (int c = 0; c < 11; c++) begin
            destination_full = (c >= 2 && c <= 4);
            #1;
            checks++;
            if (obs() !== {5'b00010, 1'b1, !destination_full, (c == 10)}) begin
                errors++;
                $display("FAIL bp_cycle%0d: got %b expected %b", c, obs(),
                         {5'b00010, 1'b1, !destination_full, (c == 10)});
            end
            tick();
        end
        destination_full = 1'b0;
        #1;
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL bp_release: got %b expected %b", obs(), 8'h00);
        end
    endtask

    task automatic test_atomic_wrap();
        do_reset();
        request_in = 5'b10000;
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 3) request_in = 5'b00011;
            #1;
            checks++;
            if (obs() !== {5'b10000, 1'b1, 1'b1, (k == 7)}) begin
                errors++;
                $display("FAIL atomic_flit%0d: got %b expected %b", k, obs(),
                         {5'b10000, 1'b1, 1'b1, (k == 7)});
            end
            tick();
        end
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL atomic_bubble: got %b expected %b", obs(), 8'h00);
        end
        tick();
        checks++;
        if (obs() !== {5'b00001, 3'b110}) begin
            errors++;
            $display("FAIL wrap_next_grant: got %b expected %b", obs(), {5'b00001, 3'b110});
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        // Complete one packet for port 1 so the pointer moves away from 0.
        request_in = 5'b00010;
        tick();
        request_in = 5'b00100;
        for (int k = 0; k < 8; k++) tick();
        tick();
        checks++;
        if (obs() !== {5'b00100, 3'b110}) begin
            errors++;
            $display("FAIL midrst_setup_grant: got %b expected %b", obs(), {5'b00100, 3'b110});
        end
        for (int k = 0; k < 4; k++) tick();
        // Now at flit 5 of the port-2 packet.
        reset = 1'b0;
        #1;
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL midrst_async_drop: got %b expected %b", obs(), 8'h00);
        end
        tick();
        reset      = 1'b1;
        request_in = 5'b00110;
        #1;
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL midrst_idle_after_release: got %b expected %b", obs(), 8'h00);
        end
        tick();
        checks++;
        if (obs() !== {5'b00010, 3'b110}) begin
            errors++;
            $display("FAIL midrst_pointer_cleared: got %b expected %b", obs(), {5'b00010, 3'b110});
        end
    endtask

    task automatic test_priority_mode();
        logic [4:0] exp_g [3];
`ifdef ARB_FIXED_PRIORITY_EN
        exp_g[0] = 5'b01000;
        exp_g[1] = 5'b01000;
        exp_g[2] = 5'b01000;
`else
        exp_g[0] = 5'b00001;
        exp_g[1] = 5'b01000;
        exp_g[2] = 5'b00001;
`endif
        do_reset();
        request_in = 5'b01001;
        tick();
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (obs() !== {exp_g[p], 3'b110}) begin
                errors++;
                $display("FAIL prio_arb%0d: got %b expected %b", p, obs(), {exp_g[p], 3'b110});
            end
            for (int k = 0; k < 9; k++) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors           = 0;
        checks           = 0;
        reset            = 1'b0;
        request_in       = '0;
        destination_full = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_atomic_wrap();
        test_reset_mid_packet();
        test_priority_mode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- Per-output-port packet arbiter for the 5-port mesh router, one instance per output direction.
- Collects the one-hot request bits that the input ports address to this output.
- Grants one requester at a time with round-robin priority and holds the grant for a whole packet.
- Paces flit transfer against the downstream full flag and pulses completion so the granted input port can release its request.

Parameters:
- NUM_PORTS, 5, number of requesting input ports; bit 4..0 = N, S, E, W, Local.
- FLITS_PER_PACKET, 8, flits per packet (packet_size / flit_size = 32/4).
- COUNT_WIDTH, 3, width of the flit counter; must satisfy 2^COUNT_WIDTH >= FLITS_PER_PACKET.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- request_in  input  NUM_PORTS  bit i = input port i requests this output (bit i of that port's request_vector).
- destination_full  input  1  downstream buffer full; no flit may be sent while high.
- grant  output  NUM_PORTS  one-hot registered grant; 0 when idle.
- grant_valid  output  1  high while a packet owns the output.
- send_flit  output  1  a flit transfers this cycle; equals grant_valid & ~destination_full.
- packet_done  output  1  one-cycle pulse in the cycle the last flit is sent.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous deassert at the board level):
  - state=IDLE, grant=0, grant_valid=0, packet_done=0, flit counter=0.
  - Priority pointer=0, so port 0 (Local) has highest priority.
- FSM states:
  - IDLE:
    - If request_in != 0, select the first set bit searching upward from the pointer, wrapping mod NUM_PORTS.
    - Register the one-hot grant, clear the counter, go to BUSY.
    - Latency: request seen at edge t gives grant and grant_valid high after edge t.
  - BUSY:
    - Each cycle with destination_full=0: send_flit=1 (combinational) and the counter increments at the next edge.
    - Each cycle with destination_full=1: send_flit=0 and the counter holds.
    - When send_flit=1 and counter==FLITS_PER_PACKET-1:
      - packet_done=1 (combinational, same cycle).
      - At the edge: state->IDLE, grant->0, pointer->(granted index+1) mod NUM_PORTS.
- Back-to-back packets: IDLE always costs one bubble cycle, so the minimum grant-to-grant spacing is FLITS_PER_PACKET+1 cycles.
- Grant is packet-atomic:
  - request_in changes in BUSY (including the granted bit dropping) are ignored until packet_done.
  - New requesters wait.
- Only one grant bit is ever set; grant=0 whenever grant_valid=0.
- destination_full high for an unbounded time holds BUSY indefinitely with no timeout.
- Pointer wrap: after granting port NUM_PORTS-1, the pointer becomes 0.
- Simultaneous events:
  - A request arriving in the packet_done cycle is evaluated in the following IDLE cycle.
  - It uses the already-updated pointer.
- Reset mid-packet: all outputs drop immediately (asynchronously); the in-flight packet is abandoned and the counter cleared.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined:
  - Fixed priority; the highest-index requesting bit wins (N > S > E > W > Local).
  - The pointer register is not implemented.
  - All other timing is unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Reset then single request: request_in=5'b00100 held, destination_full=0.
  - grant=5'b00100 one cycle after the request.
  - send_flit high for exactly 8 consecutive cycles.
  - packet_done pulses with the 8th flit.
  - grant=0 the next cycle.
- Round-robin fairness: request_in=5'b11111 held for 4 packets.
  - Grants in order 00001, 00010, 00100, 01000.
  - Each grant lasts 8 cycles, separated by 1 idle cycle.
- Backpressure: port 1 granted; destination_full=1 for 3 cycles after flit 2.
  - send_flit low for those 3 cycles, counter holds.
  - packet_done arrives 11 cycles after grant start.
- Atomicity and wrap: port 4 granted; request_in switches to 5'b00011 mid-packet.
  - grant stays 5'b10000 until packet_done.
  - Next grant is 5'b00001, because the pointer wraps to 0.
- Reset mid-packet: reset=0 at flit 5.
  - grant, grant_valid, send_flit and packet_done are 0 in the same cycle.
  - After release, request_in=5'b00110 yields grant=5'b00010, because the pointer has returned to 0.
- ARB_FIXED_PRIORITY_EN defined, request_in=5'b01001 held.
  - grant=5'b01000 on every arbitration; port 0 never served while bit 3 is asserted.
